// File: rtl/ap_mult_pkg.sv
// rtl/ap_mult_pkg.sv - shared types and helpers for the approximate multiplier final adder
package ap_mult_pkg;

    localparam int AP_PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } cpa_state_t;

    // Width of the chunk index for a W-bit row split into CHUNK-bit slices.
    // A single-chunk adder still gets a 1-bit index so the register exists.
    function automatic int nch(input int w, input int chunk);
        int n;
        n = w / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ap_chunk_add.sv
// rtl/ap_chunk_add.sv - combinational CHUNK-bit adder with carry in and carry out
//
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry in
//   sum   : CHUNK-bit sum
//   cout  : carry out of the top bit
module ap_chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/ap_wall_final_cpa.sv
// rtl/ap_wall_final_cpa.sv - serial chunked carry-propagate adder for the approximate Wallace multiplier
//
// Adds the sum and carry rows left by the compressor tree CHUNK bits per cycle and
// presents the W-bit product behind a valid/ready handshake. One operation in flight.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake; in_ready is high only in IDLE
//   row_s, row_c        : sum and carry rows, sampled only at the accept edge
//   out_valid/out_ready : output handshake; out_valid is high only in DONE
//   prod                : (row_s + row_c) mod 2^W, defined while out_valid is high
//   busy                : high in ADD and DONE
//   ovf                 : carry out of bit W-1 (only when AP_FINAL_ADD_OVF_EN is defined)
//
// Build option: AP_FINAL_ADD_OVF_EN adds the ovf output.
module ap_wall_final_cpa
    import ap_mult_pkg::*;
#(
    parameter int W     = AP_PROD_W,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] row_s,
    input  logic [W-1:0] row_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] prod,
    output logic         busy
`ifdef AP_FINAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int            NCH    = W / CHUNK;
    localparam int            KW     = nch(W, CHUNK);
    localparam logic [KW-1:0] LAST_K = KW'(NCH - 1);

    generate
        if ((W % CHUNK) != 0) begin : g_bad_chunk
            $error("ap_wall_final_cpa: W must be a multiple of CHUNK");
        end
    endgenerate

    cpa_state_t       r_state;
    cpa_state_t       w_next_state;
    logic [W-1:0]     r_s;
    logic [W-1:0]     r_c;
    logic [W-1:0]     r_prod;
    logic [KW-1:0]    r_k;
    logic             r_cy;
`ifdef AP_FINAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic [CHUNK-1:0] w_s_chunk;
    logic [CHUNK-1:0] w_c_chunk;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_k == LAST_K);

    // Select chunk k of both captured rows for the single shared adder.
    always_comb begin
        w_s_chunk = '0;
        w_c_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_k == KW'(i)) begin
                w_s_chunk = r_s[i*CHUNK +: CHUNK];
                w_c_chunk = r_c[i*CHUNK +: CHUNK];
            end
        end
    end

    ap_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a    (w_s_chunk),
        .b    (w_c_chunk),
        .cin  (r_cy),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ADD;
            ADD:     if (w_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, never on the partner's signal.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE:    in_ready = 1'b1;
            ADD:     busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_c    <= '0;
            r_prod <= '0;
            r_k    <= '0;
            r_cy   <= 1'b0;
`ifdef AP_FINAL_ADD_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_s  <= row_s;
            r_c  <= row_c;
            r_k  <= '0;
            r_cy <= 1'b0;
        end else if (r_state == ADD) begin
            r_cy <= w_cout;
            r_k  <= r_k + KW'(1);
            for (int i = 0; i < NCH; i++) begin
                if (r_k == KW'(i)) begin
                    r_prod[i*CHUNK +: CHUNK] <= w_sum;
                end
            end
`ifdef AP_FINAL_ADD_OVF_EN
            if (w_last) begin
                r_ovf <= w_cout;
            end
`endif
        end
    end

    assign prod = r_prod;
`ifdef AP_FINAL_ADD_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_ap_wall_final_cpa.sv
// tb/tb_ap_wall_final_cpa.sv - directed and random checks of the serial final adder
module tb_ap_wall_final_cpa;
    import ap_mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] row_s = '0;
    logic [15:0] row_c = '0;
    logic        out_ready = 1'b1;
    logic        iv4 = 1'b0, iv8 = 1'b0, iv16 = 1'b0;
    logic        ir4, ir8, ir16;
    logic        ov4, ov8, ov16;
    logic        bz4, bz8, bz16;
    logic [15:0] p4, p8, p16;
`ifdef AP_FINAL_ADD_OVF_EN
    logic        ovf4, ovf8, ovf16;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ap_wall_final_cpa #(.W(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .row_s(row_s), .row_c(row_c),
        .out_valid(ov4), .out_ready(out_ready), .prod(p4), .busy(bz4)
`ifdef AP_FINAL_ADD_OVF_EN
        , .ovf(ovf4)
`endif
    );

    ap_wall_final_cpa #(.W(16), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .row_s(row_s), .row_c(row_c),
        .out_valid(ov8), .out_ready(out_ready), .prod(p8), .busy(bz8)
`ifdef AP_FINAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    ap_wall_final_cpa #(.W(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .row_s(row_s), .row_c(row_c),
        .out_valid(ov16), .out_ready(out_ready), .prod(p16), .busy(bz16)
`ifdef AP_FINAL_ADD_OVF_EN
        , .ovf(ovf16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept4(input logic [15:0] s, input logic [15:0] c);
        chk("accept_in_ready", 32'(ir4), 32'd1);
        row_s = s;
        row_c = c;
        iv4   = 1'b1;
        tick();
        iv4   = 1'b0;
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (ov4 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic op_all(input logic [15:0] s, input logic [15:0] c);
        int          n = 0;
        bit          d4 = 1'b0, d8 = 1'b0, d16 = 1'b0;
        logic [16:0] full;
        while (!(ir4 && ir8 && ir16) && n < 20) begin
            tick();
            n++;
        end
        chk("all_idle", {29'd0, ir4, ir8, ir16}, 32'd7);
        full  = {1'b0, s} + {1'b0, c};
        row_s = s;
        row_c = c;
        iv4 = 1'b1; iv8 = 1'b1; iv16 = 1'b1;
        tick();
        iv4 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
        n = 0;
        while (!(d4 && d8 && d16) && n < 10) begin
            tick();
            n++;
            if (!d4 && ov4) begin
                d4 = 1'b1;
                chk("rnd_lat4", 32'(n), 32'd4);
                chk("rnd_prod4", {16'd0, p4}, {16'd0, full[15:0]});
`ifdef AP_FINAL_ADD_OVF_EN
                chk("rnd_ovf4", 32'(ovf4), 32'(full[16]));
`endif
            end
            if (!d8 && ov8) begin
                d8 = 1'b1;
                chk("rnd_lat8", 32'(n), 32'd2);
                chk("rnd_prod8", {16'd0, p8}, {16'd0, full[15:0]});
            end
            if (!d16 && ov16) begin
                d16 = 1'b1;
                chk("rnd_lat16", 32'(n), 32'd1);
                chk("rnd_prod16", {16'd0, p16}, {16'd0, full[15:0]});
`ifdef AP_FINAL_ADD_OVF_EN
                chk("rnd_ovf16", 32'(ovf16), 32'(full[16]));
`endif
            end
        end
        chk("rnd_done", {29'd0, d4, d8, d16}, 32'd7);
    endtask

    initial begin
        int n;
        int last4, last8, last16;

        // Reset state, both while held and after release
        repeat (3) tick();
        chk("rst_in_ready", 32'(ir4), 32'd1);
        chk("rst_out_valid", 32'(ov4), 32'd0);
        chk("rst_prod", {16'd0, p4}, 32'd0);
        chk("rst_busy", 32'(bz4), 32'd0);
`ifdef AP_FINAL_ADD_OVF_EN
        chk("rst_ovf", 32'(ovf4), 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(ir4), 32'd1);

        // 1: simple carry ripple
        accept4(16'h00FF, 16'h0001);
        chk("t1_busy", 32'(bz4), 32'd1);
        chk("t1_in_ready_add", 32'(ir4), 32'd0);
        wait4(n);
        chk("t1_latency", 32'(n), 32'd4);
        chk("t1_prod", {16'd0, p4}, 32'h0100);
`ifdef AP_FINAL_ADD_OVF_EN
        chk("t1_ovf", 32'(ovf4), 32'd0);
`endif
        tick();
        chk("t1_out_valid_drop", 32'(ov4), 32'd0);

        // 2: carry across every chunk; rows change after accept and must be ignored
        accept4(16'h0F0F, 16'h0101);
        row_s = 16'hFFFF;
        row_c = 16'hFFFF;
        wait4(n);
        chk("t2_latency", 32'(n), 32'd4);
        chk("t2_prod", {16'd0, p4}, 32'h1010);
        tick();

        // 3: wrap modulo 2^16
        accept4(16'hFFFF, 16'h0001);
        wait4(n);
        chk("t3_latency", 32'(n), 32'd4);
        chk("t3_prod", {16'd0, p4}, 32'h0000);
`ifdef AP_FINAL_ADD_OVF_EN
        chk("t3_ovf", 32'(ovf4), 32'd1);
`endif
        tick();

        // 4: back-pressure in DONE with a pending new pair
        out_ready = 1'b0;
        accept4(16'h1234, 16'h1111);
        wait4(n);
        chk("t4_latency", 32'(n), 32'd4);
        row_s = 16'h0001;
        row_c = 16'h0002;
        iv4   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", 32'(ov4), 32'd1);
            chk("t4_hold_prod", {16'd0, p4}, 32'h2345);
            chk("t4_hold_in_ready", 32'(ir4), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t4_release_valid", 32'(ov4), 32'd0);
        chk("t4_release_in_ready", 32'(ir4), 32'd1);
        tick();
        iv4 = 1'b0;
        wait4(n);
        chk("t4_next_latency", 32'(n), 32'd4);
        chk("t4_next_prod", {16'd0, p4}, 32'h0003);
        tick();

        // 5: reset during the second ADD cycle aborts the operation
        accept4(16'h4444, 16'h1111);
        tick();
        rst = 1'b1;
        #2;
        chk("t5_rst_prod", {16'd0, p4}, 32'd0);
        chk("t5_rst_out_valid", 32'(ov4), 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_release_in_ready", 32'(ir4), 32'd1);
        chk("t5_release_busy", 32'(bz4), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_out_valid", 32'(ov4), 32'd0);
        end
        accept4(16'hABCD, 16'h1234);
        wait4(n);
        chk("t5_next_latency", 32'(n), 32'd4);
        chk("t5_next_prod", {16'd0, p4}, 32'hBE01);
        tick();

        // 6a: issue interval with in_valid and out_ready held high
        row_s = 16'h1357;
        row_c = 16'h2468;
        iv4 = 1'b1; iv8 = 1'b1; iv16 = 1'b1;
        last4 = -1; last8 = -1; last16 = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (ir4) begin
                if (last4 >= 0) chk("t6_interval4", 32'(cyc - last4), 32'd6);
                last4 = cyc;
            end
            if (ir8) begin
                if (last8 >= 0) chk("t6_interval8", 32'(cyc - last8), 32'd4);
                last8 = cyc;
            end
            if (ir16) begin
                if (last16 >= 0) chk("t6_interval16", 32'(cyc - last16), 32'd3);
                last16 = cyc;
            end
            tick();
        end
        iv4 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;

        // 6b: random pairs on all three chunk widths, plus the corners
        op_all(16'hFFFF, 16'hFFFF);
        op_all(16'h0000, 16'h0000);
        op_all(16'h8000, 16'h8000);
        for (int i = 0; i < 3000; i++) begin
            op_all(16'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
